// File: rtl/ysyx_22050598_ifu_pkg.sv
// ---------------------------------------------------------------------------
// ysyx_22050598_ifu_pkg
// Shared definitions for the ysyx_22050598 instruction fetch unit:
//   - FSM state encodings (3-bit)
//   - default reset PC
//   - instruction word width
// No ports; imported by the IFU top and its next-PC sub-module.
// ---------------------------------------------------------------------------
package ysyx_22050598_ifu_pkg;

    localparam int          ysyx_22050598_INST_W   = 32;
    localparam logic [63:0] ysyx_22050598_RESET_PC = 64'h0000_0000_8000_0000;

    typedef enum logic [2:0] {
        ysyx_22050598_IFU_IDLE  = 3'd0,
        ysyx_22050598_IFU_REQ   = 3'd1,
        ysyx_22050598_IFU_WAIT  = 3'd2,
        ysyx_22050598_IFU_VALID = 3'd3,
        ysyx_22050598_IFU_HALT  = 3'd4
    } ysyx_22050598_ifu_state_t;

endpackage

// File: rtl/ysyx_22050598_ifu_npc.sv
// ---------------------------------------------------------------------------
// ysyx_22050598_NPC
// Purely combinational next-PC select for a retiring instruction.
// Priority: ebreak > misaligned jump target > taken jump > sequential +4.
// Ports:
//   i_pc        current PC
//   i_j_flag    execute reports a taken jump
//   i_j_pc      jump target
//   i_ebreak    retiring instruction is ebreak
//   o_npc       PC to load on retirement (unchanged PC when stopping)
//   o_stop      retirement stops the fetch unit (ebreak or fault)
//   o_fault     stop is caused by a misaligned jump target
// ---------------------------------------------------------------------------
module ysyx_22050598_NPC
    import ysyx_22050598_ifu_pkg::*;
(
    input  logic [63:0] i_pc,
    input  logic        i_j_flag,
    input  logic [63:0] i_j_pc,
    input  logic        i_ebreak,
    output logic [63:0] o_npc,
    output logic        o_stop,
    output logic        o_fault
);

    logic w_misalign;

    assign w_misalign = i_j_flag && (i_j_pc[1:0] != 2'b00);

    always_comb begin
        o_stop  = i_ebreak || w_misalign;
        // ebreak masks a simultaneous bad jump, so it is never reported as a fault
        o_fault = !i_ebreak && w_misalign;
        o_npc   = i_pc + 64'd4;
        if (i_ebreak || w_misalign) begin
            o_npc = i_pc;
        end else if (i_j_flag) begin
            o_npc = i_j_pc;
        end
    end

endmodule

// File: rtl/ysyx_22050598_ifu.sv
// ---------------------------------------------------------------------------
// ysyx_22050598_ifu
// Single-outstanding instruction fetch unit. Holds the architectural PC,
// fetches one word at a time, presents it to decode and advances the PC on
// retirement (PC+4 or jump target). Stops on ebreak or misaligned target.
// Ports:
//   clk, rst                         clock, async active-high reset
//   imem_req_valid/ready, imem_addr  fetch request channel (addr = PC)
//   imem_resp_valid, imem_resp_data  one-cycle response pulse + word
//   inst_valid/ready, inst, inst_pc  instruction handed to decode
//   j_flag, j_pc, ebreak_flag        execute outcome, sampled at handshake
//   halted, fetch_fault              stop status
//   retire_cnt                       number of consumed instructions
// ---------------------------------------------------------------------------
module ysyx_22050598_ifu
    import ysyx_22050598_ifu_pkg::*;
#(
    parameter logic [63:0] RESET_PC = ysyx_22050598_RESET_PC
) (
    input  logic                            clk,
    input  logic                            rst,
    output logic                            imem_req_valid,
    input  logic                            imem_req_ready,
    output logic [63:0]                     imem_addr,
    input  logic                            imem_resp_valid,
    input  logic [ysyx_22050598_INST_W-1:0] imem_resp_data,
    output logic                            inst_valid,
    input  logic                            inst_ready,
    output logic [ysyx_22050598_INST_W-1:0] inst,
    output logic [63:0]                     inst_pc,
    input  logic                            j_flag,
    input  logic [63:0]                     j_pc,
    input  logic                            ebreak_flag,
    output logic                            halted,
    output logic                            fetch_fault,
    output logic [63:0]                     retire_cnt
);

    ysyx_22050598_ifu_state_t r_state, w_next_state;

    logic [63:0]                     r_pc;
    logic [ysyx_22050598_INST_W-1:0] r_inst;
    logic [63:0]                     r_retire_cnt;
    logic                            r_fault;

    logic        w_fire;
    logic [63:0] w_npc;
    logic        w_stop;
    logic        w_fault;

    assign w_fire = (r_state == ysyx_22050598_IFU_VALID) && inst_ready;

    ysyx_22050598_NPC u_npc (
        .i_pc     (r_pc),
        .i_j_flag (j_flag),
        .i_j_pc   (j_pc),
        .i_ebreak (ebreak_flag),
        .o_npc    (w_npc),
        .o_stop   (w_stop),
        .o_fault  (w_fault)
    );

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ysyx_22050598_IFU_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state logic
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ysyx_22050598_IFU_IDLE:  w_next_state = ysyx_22050598_IFU_REQ;
            ysyx_22050598_IFU_REQ: begin
                if (imem_req_ready) w_next_state = ysyx_22050598_IFU_WAIT;
            end
            ysyx_22050598_IFU_WAIT: begin
                if (imem_resp_valid) w_next_state = ysyx_22050598_IFU_VALID;
            end
            ysyx_22050598_IFU_VALID: begin
                if (inst_ready) begin
                    w_next_state = w_stop ? ysyx_22050598_IFU_HALT : ysyx_22050598_IFU_REQ;
                end
            end
            ysyx_22050598_IFU_HALT:  w_next_state = ysyx_22050598_IFU_HALT;
            default:                 w_next_state = ysyx_22050598_IFU_IDLE;
        endcase
    end

    // Outputs decoded from registered state only
    always_comb begin
        imem_req_valid = (r_state == ysyx_22050598_IFU_REQ);
        inst_valid     = (r_state == ysyx_22050598_IFU_VALID);
        halted         = (r_state == ysyx_22050598_IFU_HALT);
        fetch_fault    = r_fault;
        imem_addr      = r_pc;
        inst_pc        = r_pc;
        inst           = r_inst;
        retire_cnt     = r_retire_cnt;
    end

    // PC, instruction latch, retire counter and fault flag
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pc         <= RESET_PC;
            r_inst       <= '0;
            r_retire_cnt <= '0;
            r_fault      <= 1'b0;
        end else begin
            // responses arriving outside WAIT are stray and must not disturb inst
            if ((r_state == ysyx_22050598_IFU_WAIT) && imem_resp_valid) begin
                r_inst <= imem_resp_data;
            end
            if (w_fire) begin
                r_retire_cnt <= r_retire_cnt + 64'd1;
                r_pc         <= w_npc;
                if (w_fault) r_fault <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_ysyx_22050598_ifu.sv
// ---------------------------------------------------------------------------
// tb_ysyx_22050598_ifu
// Bench for the fetch unit: a configurable instruction memory, an
// architectural model of PC / retire count / halt status, a per-cycle
// compare process and directed scenarios with literal expectations.
// ---------------------------------------------------------------------------
module tb_ysyx_22050598_ifu;

    localparam logic [63:0] RST_PC = 64'h0000_0000_8000_0000;

    logic        clk;
    logic        rst;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [63:0] imem_addr;
    logic        imem_resp_valid;
    logic [31:0] imem_resp_data;
    logic        inst_valid;
    logic        inst_ready;
    logic [31:0] inst;
    logic [63:0] inst_pc;
    logic        j_flag;
    logic [63:0] j_pc;
    logic        ebreak_flag;
    logic        halted;
    logic        fetch_fault;
    logic [63:0] retire_cnt;

    int checks = 0;
    int errors = 0;
    bit cmp_en = 0;

    ysyx_22050598_ifu dut (
        .clk             (clk),
        .rst             (rst),
        .imem_req_valid  (imem_req_valid),
        .imem_req_ready  (imem_req_ready),
        .imem_addr       (imem_addr),
        .imem_resp_valid (imem_resp_valid),
        .imem_resp_data  (imem_resp_data),
        .inst_valid      (inst_valid),
        .inst_ready      (inst_ready),
        .inst            (inst),
        .inst_pc         (inst_pc),
        .j_flag          (j_flag),
        .j_pc            (j_pc),
        .ebreak_flag     (ebreak_flag),
        .halted          (halted),
        .fetch_fault     (fetch_fault),
        .retire_cnt      (retire_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [63:0] a);
        return {~a[15:0] ^ a[31:16], a[15:0]};
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    // ---------------- memory model ----------------
    int          mem_stall = 0;
    int          mem_lat   = 0;
    bit          spur      = 0;
    int          acc_cnt   = 0;
    bit          m_pending, m_new_req, m_last_valid;
    int          m_stall_left, m_lat_left;
    logic [63:0] m_last_addr, m_req_addr;

    initial begin
        imem_req_ready  = 1'b0;
        imem_resp_valid = 1'b0;
        imem_resp_data  = '0;
        m_pending = 0; m_new_req = 1; m_last_valid = 0;
        m_stall_left = 0; m_lat_left = 0;
        m_last_addr = '0; m_req_addr = '0;
        forever begin
            @(negedge clk);
            imem_resp_valid = 1'b0;
            if (rst) begin
                imem_req_ready = 1'b0;
                m_pending = 0; m_new_req = 1; m_last_valid = 0;
            end else begin
                if (imem_req_ready && m_last_valid) begin
                    m_pending = 1; m_lat_left = mem_lat; m_req_addr = m_last_addr;
                    acc_cnt++; imem_req_ready = 1'b0; m_new_req = 1;
                end
                if (m_pending) begin
                    if (m_lat_left == 0) begin
                        imem_resp_valid = 1'b1;
                        imem_resp_data  = mem_word(m_req_addr);
                        m_pending = 0;
                    end else begin
                        m_lat_left--;
                    end
                end else if (spur && !imem_req_valid) begin
                    imem_resp_valid = 1'b1;
                    imem_resp_data  = 32'hDEAD_BEEF;
                    spur = 0;
                end
                if (imem_req_valid && !m_pending) begin
                    if (m_new_req) begin m_stall_left = mem_stall; m_new_req = 0; end
                    if (m_stall_left > 0) begin imem_req_ready = 1'b0; m_stall_left--; end
                    else imem_req_ready = 1'b1;
                end else begin
                    imem_req_ready = 1'b0;
                end
                m_last_valid = imem_req_valid;
                m_last_addr  = imem_addr;
            end
        end
    end

    // ---------------- architectural model ----------------
    // The driver raises inst_ready only while an instruction is offered, so a
    // high inst_ready at an edge is a retirement.
    logic [63:0] m_pc, m_cnt;
    logic        m_halt, m_fault;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_pc <= RST_PC; m_cnt <= '0; m_halt <= 1'b0; m_fault <= 1'b0;
        end else if (inst_ready) begin
            m_cnt <= m_cnt + 64'd1;
            if (ebreak_flag) begin
                m_halt <= 1'b1;
            end else if (j_flag && (j_pc % 4 != 0)) begin
                m_halt <= 1'b1; m_fault <= 1'b1;
            end else if (j_flag) begin
                m_pc <= j_pc;
            end else begin
                m_pc <= m_pc + 64'd4;
            end
        end
    end

    always @(negedge clk) begin
        if (cmp_en) begin
            chk("imem_addr", imem_addr, m_pc);
            chk("inst_pc", inst_pc, m_pc);
            chk("retire_cnt", retire_cnt, m_cnt);
            chk("halted", 64'(halted), 64'(m_halt));
            chk("fetch_fault", 64'(fetch_fault), 64'(m_fault));
            chk("req_inst_excl", 64'(imem_req_valid & inst_valid), 64'd0);
            if (m_halt) begin
                chk("halt_no_req", 64'(imem_req_valid), 64'd0);
                chk("halt_no_inst", 64'(inst_valid), 64'd0);
            end
            if (inst_valid) chk("inst_word", 64'(inst), 64'(mem_word(m_pc)));
        end
    end

    // ---------------- driver helpers ----------------
    task automatic reset_checks();
        chk("rst_imem_addr", imem_addr, RST_PC);
        chk("rst_inst_pc", inst_pc, RST_PC);
        chk("rst_inst", 64'(inst), 64'd0);
        chk("rst_retire_cnt", retire_cnt, 64'd0);
        chk("rst_halted", 64'(halted), 64'd0);
        chk("rst_fault", 64'(fetch_fault), 64'd0);
        chk("rst_req_valid", 64'(imem_req_valid), 64'd0);
        chk("rst_inst_valid", 64'(inst_valid), 64'd0);
    endtask

    task automatic do_reset();
        rst = 1'b1; inst_ready = 1'b0;
        repeat (3) @(negedge clk);
        reset_checks();
        rst = 1'b0;
    endtask

    task automatic wait_valid();
        int t = 0;
        while (!inst_valid && t < 100) begin @(negedge clk); t++; end
        chk("inst_valid_wait", 64'(inst_valid), 64'd1);
    endtask

    task automatic retire_one(input int hold, input bit jf, input logic [63:0] jpc, input bit eb,
                              output logic [31:0] got_inst, output logic [63:0] got_pc);
        logic [63:0] c0;
        wait_valid();
        got_inst = inst; got_pc = inst_pc; c0 = retire_cnt;
        for (int i = 0; i < hold; i++) begin
            j_flag = 1'($urandom_range(0, 1)); ebreak_flag = 1'($urandom_range(0, 1));
            j_pc = {$urandom, $urandom};
            @(negedge clk);
            chk("bp_inst_stable", 64'(inst), 64'(got_inst));
            chk("bp_pc_stable", inst_pc, got_pc);
            chk("bp_cnt_stable", retire_cnt, c0);
            chk("bp_no_req", 64'(imem_req_valid), 64'd0);
        end
        j_flag = jf; j_pc = jpc; ebreak_flag = eb; inst_ready = 1'b1;
        @(negedge clk);
        inst_ready = 1'b0;
        j_flag = 1'($urandom_range(0, 1)); ebreak_flag = 1'($urandom_range(0, 1));
        j_pc = {$urandom, $urandom};
    endtask

    // ---------------- directed scenarios ----------------
    logic [31:0] gi;
    logic [63:0] gp;
    int          a0, t;

    initial begin
        rst = 1'b1; inst_ready = 1'b0; j_flag = 1'b0; j_pc = '0; ebreak_flag = 1'b0;
        repeat (2) @(negedge clk);
        cmp_en = 1;
        do_reset();

        // first request one cycle after reset release, then sequential retirement
        @(negedge clk);
        chk("first_req_valid", 64'(imem_req_valid), 64'd1);
        chk("first_req_addr", imem_addr, 64'h8000_0000);
        retire_one(0, 0, '0, 0, gi, gp);
        chk("seq0_pc", gp, 64'h8000_0000);
        chk("seq0_inst", 64'(gi), 64'h7FFF_0000);
        retire_one(0, 0, '0, 0, gi, gp);
        chk("seq1_pc", gp, 64'h8000_0004);
        wait_valid();
        mem_stall = 4; mem_lat = 3;
        retire_one(0, 0, '0, 0, gi, gp);
        chk("seq2_pc", gp, 64'h8000_0008);
        chk("seq_cnt3", retire_cnt, 64'd3);
        chk("seq_next_addr", imem_addr, 64'h8000_000C);

        // memory stall: one accepted request, word latched after late response
        a0 = acc_cnt;
        wait_valid();
        chk("stall_one_accept", 64'(acc_cnt - a0), 64'd1);
        mem_stall = 0; mem_lat = 0;
        retire_one(0, 0, '0, 0, gi, gp);
        chk("stall_inst", 64'(gi), 64'h7FF3_000C);
        chk("stall_pc", gp, 64'h8000_000C);

        // decode backpressure with a stray response, then a taken jump
        wait_valid();
        spur = 1;
        a0 = acc_cnt;
        retire_one(5, 1, 64'h8000_0100, 0, gi, gp);
        chk("bp_no_accept", 64'(acc_cnt - a0), 64'd0);
        chk("bp_inst", 64'(gi), 64'h7FEF_0010);
        chk("jump_cnt", retire_cnt, 64'd5);
        chk("jump_req_valid", 64'(imem_req_valid), 64'd1);
        chk("jump_addr", imem_addr, 64'h8000_0100);

        // misaligned target faults and stops fetching
        a0 = acc_cnt;
        retire_one(0, 1, 64'h8000_0102, 0, gi, gp);
        chk("fault_halted", 64'(halted), 64'd1);
        chk("fault_flag", 64'(fetch_fault), 64'd1);
        chk("fault_cnt", retire_cnt, 64'd6);
        chk("fault_pc", imem_addr, 64'h8000_0100);
        repeat (10) @(negedge clk);
        chk("fault_no_more_req", 64'(acc_cnt - a0), 64'd1);

        // ebreak wins over a simultaneous jump
        do_reset();
        retire_one(0, 0, '0, 0, gi, gp);
        retire_one(0, 1, 64'h8000_0200, 1, gi, gp);
        chk("ebreak_pc_seen", gp, 64'h8000_0004);
        chk("ebreak_halted", 64'(halted), 64'd1);
        chk("ebreak_fault", 64'(fetch_fault), 64'd0);
        chk("ebreak_pc", imem_addr, 64'h8000_0004);
        chk("ebreak_cnt", retire_cnt, 64'd2);

        // reset asserted while a fetch is outstanding
        rst = 1'b1;
        @(negedge clk);
        mem_lat = 6;
        rst = 1'b0;
        a0 = acc_cnt; t = 0;
        while (acc_cnt == a0 && t < 50) begin @(negedge clk); t++; end
        chk("midwait_accept", 64'(acc_cnt - a0), 64'd1);
        @(negedge clk);
        rst = 1'b1;
        #1;
        reset_checks();
        mem_lat = 0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        retire_one(0, 0, '0, 0, gi, gp);
        chk("restart_pc", gp, 64'h8000_0000);
        chk("restart_inst", 64'(gi), 64'h7FFF_0000);
        chk("restart_cnt", retire_cnt, 64'd1);

        repeat (3) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/ysyx_22050598_ifu.md
# ysyx_22050598_ifu

Instruction fetch unit of the single-issue ysyx_22050598 core, directly upstream of decode/execute. It holds the architectural PC, issues one 32-bit fetch at a time to instruction memory over a valid/ready request channel, and captures the response. It presents the instruction plus its PC to decode and advances the PC when that instruction retires. Retirement takes either PC+4 or the execute stage's jump target. The unit halts on ebreak or a misaligned jump target.

## Interface
Parameters:
- RESET_PC, 64'h8000_0000, PC loaded on reset.

Ports:
- clk  in  1  core clock; all state updates on rising edge
- rst  in  1  asynchronous, active-high reset
- imem_req_valid  out  1  fetch request valid
- imem_req_ready  in  1  memory accepts request
- imem_addr  out  64  fetch address, equals current PC
- imem_resp_valid  in  1  response data valid, one cycle pulse
- imem_resp_data  in  32  fetched instruction word
- inst_valid  out  1  instruction available to decode
- inst_ready  in  1  decode/execute consumes instruction this cycle
- inst  out  32  instruction word
- inst_pc  out  64  PC of inst
- j_flag  in  1  execute: taken jump for the instruction being consumed
- j_pc  in  64  execute: jump target
- ebreak_flag  in  1  execute: consumed instruction is ebreak
- halted  out  1  unit stopped (ebreak or fault)
- fetch_fault  out  1  halt caused by misaligned target
- retire_cnt  out  64  count of consumed instructions

## Operation
- FSM states: IDLE, REQ, WAIT, VALID, HALT. Reset state is IDLE.
- IDLE goes to REQ unconditionally, so the first request follows reset release by one cycle.
- REQ: imem_req_valid=1 and imem_addr=pc. The FSM moves to WAIT on imem_req_valid && imem_req_ready.
- WAIT: on imem_resp_valid, the FSM latches imem_resp_data into inst and moves to VALID.
- imem_resp_valid outside WAIT is ignored, with no state change.
- VALID: inst_valid=1 and inst_pc=pc. The handshake is inst_valid && inst_ready. On the handshake:
  - retire_cnt increments by 1, modulo 2^64.
  - ebreak_flag=1: the FSM goes to HALT; the PC is unchanged; halted=1.
  - else j_flag=1 and j_pc[1:0]!=0: the FSM goes to HALT; fetch_fault=1; the PC is unchanged.
  - else j_flag=1: pc becomes j_pc and the FSM goes to REQ.
  - else: pc becomes pc+4 (64-bit, wraps) and the FSM goes to REQ.
- j_flag, j_pc and ebreak_flag are sampled only in the handshake cycle and are don't-care otherwise.
- If ebreak_flag and j_flag are both set, ebreak wins.
- HALT is terminal and is left only by rst. In HALT, imem_req_valid=0 and inst_valid=0.
- At most one request is outstanding. There is no prefetch and no speculative fetch, so no kill logic is needed.

## Timing
- Reset values: pc=RESET_PC, inst=0, retire_cnt=0, halted=0, fetch_fault=0, imem_req_valid=0, inst_valid=0, imem_addr=RESET_PC, inst_pc=RESET_PC.
- imem_req_valid, inst_valid, halted and fetch_fault are decoded from registered state only, with no input-to-output combinational path.
- imem_addr and inst_pc are driven from the pc register.
- Minimum fetch-to-retire loop with zero-wait memory, counting from request acceptance in cycle N:
  - N+1: the response is latched.
  - N+2: inst_valid is high and is consumed if inst_ready=1.
  - N+3: the next request is issued.
  - This gives 3 cycles per instruction.
- Under backpressure (inst_ready=0), inst and inst_pc hold stable for any number of cycles.
- Under memory stall (imem_req_ready=0), imem_req_valid stays high with imem_addr stable.
- Reset asserted mid-WAIT: the FSM returns to IDLE immediately. Memory shares rst, so no stale response is delivered afterwards.

## Structure
- The shared defines file holds:
  - the FSM state encodings (ysyx_22050598_IFU_IDLE/REQ/WAIT/VALID/HALT, 3-bit);
  - the RESET_PC default;
  - the instruction width constant.
- The next-PC select (ebreak / fault / jump / +4) is a natural sub-module, ysyx_22050598_NPC. It is purely combinational and is reused by a future pipelined front end.
- The retire counter stays inline.

## Test plan
- Reset release with zero-wait memory:
  - first imem_addr=0x8000_0000 one cycle after rst falls;
  - sequential instructions retire at PCs 0x8000_0000, _0004, _0008;
  - retire_cnt=3.
- Memory stalls (req_ready low 4 cycles, then response 3 cycles late) -> address held stable, exactly one request accepted, inst latched correctly.
- inst_ready low 5 cycles in VALID -> inst and inst_pc stable, no new request, retire_cnt unchanged until the handshake.
- j_flag=1, j_pc=0x8000_0100 at the handshake -> next imem_addr=0x8000_0100.
- j_pc=0x8000_0102 -> halted=1 and fetch_fault=1, no further requests.
- ebreak_flag=1 together with j_flag=1 -> halted=1, fetch_fault=0, pc unchanged, retire_cnt incremented. Asserting rst mid-WAIT afterwards restarts at RESET_PC with all outputs at reset values.
